// File: rtl/fs_pkg.sv
// Shared types for the file-system request mux: ops, FSM states,
// the name-beat width and small decode helpers.
package fs_pkg;

  typedef enum logic [1:0] {
    OP_READ   = 2'd0,
    OP_WRITE  = 2'd1,
    OP_DELETE = 2'd2,
    OP_OPEN   = 2'd3
  } fs_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARB,
    S_NAME,
    S_OP,
    S_WAIT,
    S_RESP
  } fs_state_e;

  localparam int NAME_W = 32;

  function automatic logic has_zero_byte(
    input logic [NAME_W-1:0] b
  );
    return (b[7:0] == 8'h0) || (b[15:8] == 8'h0) ||
           (b[23:16] == 8'h0) || (b[31:24] == 8'h0);
  endfunction

  // {rden, wren, del}
  function automatic logic [2:0] op_strobes(
    input fs_op_e op
  );
    return {op == OP_READ, op == OP_WRITE,
            op == OP_DELETE};
  endfunction

endpackage

// File: rtl/fs_rr_arbiter.sv
// Round-robin arbiter: search starts after the last
// accepted channel; pointer resets to channel 0.
module fs_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [N-1:0]  i_req,
  input  logic          i_accept,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_gnt_idx
);

  logic [IW-1:0] r_ptr;

  always_comb begin
    int  c;
    logic w_found;
    o_gnt     = '0;
    o_gnt_idx = r_ptr;
    w_found   = 1'b0;
    c         = 0;
    for (int i = 0; i < N; i++) begin
      c = (int'(r_ptr) + i) % N;
      if (!w_found && i_req[c]) begin
        w_found   = 1'b1;
        o_gnt[c]  = 1'b1;
        o_gnt_idx = IW'(c);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
    end else if (i_accept) begin
      r_ptr <= IW'((int'(o_gnt_idx) + 1) % N);
    end
  end

endmodule

// File: rtl/fs_mux.sv
// Multi-channel file request mux onto one backend port.
// Define FS_MUX_NAME_CACHE_EN to skip re-streaming the current file name.
module fs_mux
  import fs_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int NAME_BEATS = 4,
  parameter int BE_RD_LAT  = 1
) (
  input  logic                     CLOCK_50,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [2*NUM_CH-1:0]      req_op,
  input  logic [ADDR_W*NUM_CH-1:0] req_addr,
  input  logic [DATA_W*NUM_CH-1:0] req_data,
  output logic [NUM_CH-1:0]        rsp_valid,
  output logic                     rsp_err,
  output logic [DATA_W-1:0]        rsp_data,
  output logic                     be_rden,
  output logic                     be_wren,
  output logic                     be_del,
  output logic [31:0]              be_filename,
  output logic [ADDR_W-1:0]        be_address,
  output logic [DATA_W-1:0]        be_data,
  input  logic [DATA_W-1:0]        be_q
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int BW = (NAME_BEATS > 1) ? $clog2(NAME_BEATS) : 1;
  localparam int CW = $clog2(NAME_BEATS + 1);

  fs_state_e         r_state;
  fs_op_e            r_op;
  fs_op_e            w_op;
  logic [NUM_CH-1:0] r_ready;
  logic [NUM_CH-1:0] r_oh;
  logic [NUM_CH-1:0] r_rsp_valid;
  logic [NUM_CH-1:0] r_bound;
  logic [NUM_CH-1:0] w_gnt;
  logic [IW-1:0]     r_ch;
  logic [IW-1:0]     r_cur;
  logic [IW-1:0]     w_gnt_idx;
  logic              r_cur_vld;
  logic              r_rsp_err;
  logic              r_rden;
  logic              r_wren;
  logic              r_del;
  logic              w_accept;
  logic              w_skip;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] r_rsp_data;
  logic [NAME_W-1:0] r_fname;
  logic [NAME_W-1:0] w_beat;
  logic [NAME_W-1:0] r_name [NUM_CH][NAME_BEATS];
  logic [CW-1:0]     r_cnt [NUM_CH];
  logic [CW-1:0]     r_len [NUM_CH];
  logic [CW-1:0]     r_nidx;
  logic [1:0]        r_wcnt;

  assign w_accept = (r_state == S_IDLE) && (|req_valid);
  assign w_op     = fs_op_e'(req_op[2*r_ch +: 2]);
  assign w_addr   = req_addr[ADDR_W*r_ch +: ADDR_W];
  assign w_data   = req_data[DATA_W*r_ch +: DATA_W];
  assign w_beat   = NAME_W'(w_data);

`ifdef FS_MUX_NAME_CACHE_EN
  assign w_skip = r_cur_vld && (r_cur == r_ch);
`else
  assign w_skip = 1'b0;
`endif

  fs_rr_arbiter #(
    .N(NUM_CH)
  ) u_arb (
    .i_clk    (CLOCK_50),
    .i_rst_n  (reset_n),
    .i_req    (req_valid),
    .i_accept (w_accept),
    .o_gnt    (w_gnt),
    .o_gnt_idx(w_gnt_idx)
  );

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_op        <= OP_READ;
      r_ready     <= '0;
      r_oh        <= '0;
      r_rsp_valid <= '0;
      r_bound     <= '0;
      r_ch        <= '0;
      r_cur       <= '0;
      r_cur_vld   <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rden      <= 1'b0;
      r_wren      <= 1'b0;
      r_del       <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_rsp_data  <= '0;
      r_fname     <= '0;
      r_nidx      <= '0;
      r_wcnt      <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_cnt[c] <= '0;
        r_len[c] <= '0;
        for (int b = 0; b < NAME_BEATS; b++)
          r_name[c][b] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req_valid) begin
            r_ready <= w_gnt;
            r_oh    <= w_gnt;
            r_ch    <= w_gnt_idx;
            r_state <= S_ARB;
          end
        end
        S_ARB: begin
          r_ready <= '0;
          r_op    <= w_op;
          r_addr  <= w_addr;
          r_data  <= w_data;
          r_nidx  <= CW'(1);
          if (w_op == OP_OPEN) begin
            r_rsp_valid <= r_oh;
            r_state     <= S_RESP;
            if (r_cnt[r_ch] == CW'(NAME_BEATS)) begin
              r_rsp_err      <= 1'b1;
              r_bound[r_ch]  <= 1'b0;
              r_cnt[r_ch]    <= '0;
            end else begin
              r_name[r_ch][BW'(r_cnt[r_ch])] <= w_beat;
              if (has_zero_byte(w_beat)) begin
                r_bound[r_ch] <= 1'b1;
                r_cnt[r_ch]   <= '0;
                r_len[r_ch]   <= r_cnt[r_ch] + 1'b1;
                if (r_cur_vld && r_cur == r_ch)
                  r_cur_vld <= 1'b0;
              end else begin
                r_bound[r_ch] <= 1'b0;
                r_cnt[r_ch]   <= r_cnt[r_ch] + 1'b1;
              end
            end
          end else if (!r_bound[r_ch]) begin
            r_rsp_valid <= r_oh;
            r_rsp_err   <= 1'b1;
            r_state     <= S_RESP;
          end else if (w_skip) begin
            {r_rden, r_wren, r_del} <= op_strobes(w_op);
            r_state <= S_OP;
          end else begin
            r_fname <= r_name[r_ch][0];
            r_state <= S_NAME;
          end
        end
        S_NAME: begin
          if (r_nidx == r_len[r_ch]) begin
            r_fname   <= '0;
            r_cur     <= r_ch;
            r_cur_vld <= 1'b1;
            {r_rden, r_wren, r_del} <= op_strobes(r_op);
            r_state   <= S_OP;
          end else begin
            r_fname <= r_name[r_ch][BW'(r_nidx)];
            r_nidx  <= r_nidx + 1'b1;
          end
        end
        S_OP: begin
          {r_rden, r_wren, r_del} <= 3'b000;
          if (r_op == OP_READ) begin
            r_wcnt  <= 2'(BE_RD_LAT - 1);
            r_state <= S_WAIT;
          end else begin
            r_rsp_valid <= r_oh;
            r_state     <= S_RESP;
            if (r_op == OP_DELETE) begin
              r_bound[r_ch] <= 1'b0;
              r_cur_vld     <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (r_wcnt == 2'd0) begin
            r_rsp_data  <= be_q;
            r_rsp_valid <= r_oh;
            r_state     <= S_RESP;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        S_RESP: begin
          r_rsp_valid <= '0;
          r_rsp_err   <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready   = r_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_err     = r_rsp_err;
  assign rsp_data    = r_rsp_data;
  assign be_rden     = r_rden;
  assign be_wren     = r_wren;
  assign be_del      = r_del;
  assign be_filename = r_fname;
  assign be_address  = r_addr;
  assign be_data     = r_data;

endmodule

// File: tb/tb_fs_mux.sv
// Randomized bench for fs_mux against a rule-level model of
// channel binding, name streaming and backend timing.
module tb_fs_mux;

  localparam int NCH = 2;
  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int NB  = 4;
  localparam int LAT = 1;
  localparam int RD = 0, WR = 1, DEL = 2, OPN = 3;
`ifdef FS_MUX_NAME_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]    req_valid;
  logic [NCH-1:0]    req_ready;
  logic [2*NCH-1:0]  req_op;
  logic [AW*NCH-1:0] req_addr;
  logic [DW*NCH-1:0] req_data;
  logic [NCH-1:0]    rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_data;
  logic              be_rden, be_wren, be_del;
  logic [31:0]       be_filename;
  logic [AW-1:0]     be_address;
  logic [DW-1:0]     be_data;
  logic [DW-1:0]     be_q;

  fs_mux #(
    .NUM_CH(NCH), .DATA_W(DW), .ADDR_W(AW),
    .NAME_BEATS(NB), .BE_RD_LAT(LAT)
  ) dut (
    .CLOCK_50(clk), .reset_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr),
    .req_data(req_data), .rsp_valid(rsp_valid),
    .rsp_err(rsp_err), .rsp_data(rsp_data),
    .be_rden(be_rden), .be_wren(be_wren),
    .be_del(be_del), .be_filename(be_filename),
    .be_address(be_address), .be_data(be_data),
    .be_q(be_q)
  );

  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'd5) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h5555AAAA;
  endfunction

  // backend: read data appears LAT cycles after be_rden
  logic [3:0]  rd_pipe = '0;
  logic [31:0] ad_pipe [4];
  always @(posedge clk) begin
    rd_pipe    <= {rd_pipe[2:0], be_rden};
    ad_pipe[0] <= be_address;
    for (int i = 1; i < 4; i++) ad_pipe[i] <= ad_pipe[i-1];
  end
  assign be_q = rd_pipe[LAT-1] ? memf(ad_pipe[LAT-1]) : 32'hBAD00BAD;

  bit          m_bound [NCH];
  int          m_cnt [NCH];
  int          m_len [NCH];
  logic [31:0] m_name [NCH][NB];
  int          m_cur = -1;
  int          m_last = -1;
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit has0(input logic [31:0] b);
    for (int i = 0; i < 4; i++) if (b[8*i +: 8] == 8'h0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_bound[c] = 1'b0; m_cnt[c] = 0; m_len[c] = 0;
    end
    m_cur = -1; m_last = -1;
  endtask

  task automatic set_req(input int ch, input int op,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit v);
    req_valid[ch]        = v;
    req_op[2*ch +: 2]    = 2'(op);
    req_addr[AW*ch +: AW] = a;
    req_data[DW*ch +: DW] = d;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ready"}, req_ready, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_err}, 0);
    chk({tag, "_rdata"}, rsp_data, 0);
    chk({tag, "_strobes"}, {be_rden, be_wren, be_del}, 0);
    chk({tag, "_fname"}, be_filename, 0);
    chk({tag, "_baddr"}, be_address, 0);
    chk({tag, "_bdata"}, be_data, 0);
  endtask

  task automatic wait_ready(output int g);
    g = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != 0) begin
        g = -2;
        if ($countones(req_ready) == 1)
          for (int c = 0; c < NCH; c++) if (req_ready[c]) g = c;
        break;
      end
    end
  endtask

  // called at T+#1 (just after the accept edge)
  task automatic observe(input int ch, input int op,
                         input logic [31:0] a, input logic [31:0] d);
    int k = 0, exp_rsp = 1, rsp_off = -1, str_off = -1;
    int nstr = 0, nrdy = 0;
    bit exp_err = 1'b0, exp_str = 1'b0, got_err = 1'b0;
    logic [2:0] ekind = '0, kind = '0;
    logic [31:0] eb[$], beats[$], sa = '0, sd = '0, rdat = '0;
    logic [NCH-1:0] rv = '0;
    m_last = ch;
    if (op == OPN) exp_err = (m_cnt[ch] == NB);
    else if (!m_bound[ch]) exp_err = 1'b1;
    else begin
      exp_str = 1'b1;
      k = (CACHE && m_cur == ch) ? 0 : m_len[ch];
      exp_rsp = 1 + k + ((op == RD) ? LAT + 1 : 1);
      ekind = (op == RD) ? 3'b100 : (op == WR) ? 3'b010 : 3'b001;
    end
    for (int i = 0; i < k; i++) eb.push_back(m_name[ch][i]);
    for (int t = 1; t <= 40; t++) begin
      @(negedge clk);
      if (req_ready != 0) nrdy++;
      if (be_filename != 0) beats.push_back(be_filename);
      if (be_rden | be_wren | be_del) begin
        nstr++;
        if (str_off < 0) begin
          str_off = t; kind = {be_rden, be_wren, be_del};
          sa = be_address; sd = be_data;
        end
      end
      if (rsp_valid != 0) begin
        rsp_off = t; rv = rsp_valid;
        got_err = rsp_err; rdat = rsp_data;
        break;
      end
    end
    chk("rsp_cycle", rsp_off, exp_rsp);
    chk("rsp_chan", rv, 1 << ch);
    chk("rsp_err", got_err, exp_err);
    chk("ready_quiet", nrdy, 0);
    chk("name_beats", beats.size(), k);
    for (int i = 0; i < k && i < beats.size(); i++)
      chk("name_val", beats[i], eb[i]);
    chk("strobe_cnt", nstr, exp_str ? 1 : 0);
    if (exp_str) begin
      chk("strobe_cycle", str_off, 1 + k);
      chk("strobe_kind", kind, ekind);
      chk("be_address", sa, a);
      if (op == WR) chk("be_data", sd, d);
      if (op == RD) chk("rsp_data", rdat, memf(a));
    end
    if (op == OPN) begin
      if (m_cnt[ch] == NB) begin
        m_bound[ch] = 1'b0; m_cnt[ch] = 0;
      end else begin
        m_name[ch][m_cnt[ch]] = d;
        if (has0(d)) begin
          m_bound[ch] = 1'b1; m_len[ch] = m_cnt[ch] + 1;
          m_cnt[ch] = 0;
          if (m_cur == ch) m_cur = -1;
        end else begin
          m_bound[ch] = 1'b0; m_cnt[ch]++;
        end
      end
    end else if (exp_str) begin
      if (k > 0) m_cur = ch;
      if (op == DEL) begin m_bound[ch] = 1'b0; m_cur = -1; end
    end
  endtask

  task automatic txn(input int ch, input int op,
                     input logic [31:0] a, input logic [31:0] d);
    int g;
    set_req(ch, op, a, d, 1'b1);
    wait_ready(g);
    chk("grant", g, ch);
    if (g < 0) begin
      set_req(ch, 0, 0, 0, 1'b0);
      repeat (40) @(negedge clk);
      return;
    end
    @(posedge clk);
    #1;
    set_req(ch, int'($urandom_range(0, 3)), $urandom, $urandom, 1'b0);
    observe(ch, op, a, d);
  endtask

  initial begin
    int g, ch, op, r;
    logic [31:0] a, d;
    req_valid = '0; req_op = '0; req_addr = '0; req_data = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    txn(0, OPN, 0, 32'h0074_6261);
    txn(0, RD, 5, 0);
    txn(1, WR, 3, 32'h1234_5678);
    txn(1, OPN, 0, 32'h6463_6261);
    txn(1, OPN, 0, 32'h0000_6665);

    // both channels held valid: grants must alternate
    set_req(0, RD, 10, 0, 1'b1);
    set_req(1, RD, 11, 0, 1'b1);
    for (int n = 0; n < 4; n++) begin
      r = (m_last + 1) % NCH;
      wait_ready(g);
      chk("rr_grant", g, r);
      if (g < 0) break;
      @(posedge clk);
      #1;
      observe(g, RD, (g == 0) ? 10 : 11, 0);
    end
    set_req(0, RD, 0, 0, 1'b0);
    set_req(1, RD, 0, 0, 1'b0);

    txn(1, WR, 20, 32'hA5A5_0001);
    txn(1, WR, 21, 32'hA5A5_0002);
    repeat (5) txn(0, OPN, 0, 32'h6161_6161);
    txn(0, RD, 5, 0);
    txn(0, OPN, 0, 32'h007A_7978);
    txn(0, DEL, 9, 0);
    txn(0, WR, 9, 32'h0F0F_0F0F);

    // reset while a name is streaming
    txn(0, OPN, 0, 32'h6463_6261);
    txn(0, OPN, 0, 32'h0000_6665);
    txn(1, OPN, 0, 32'h0033_3231);
    set_req(0, RD, 7, 0, 1'b1);
    wait_ready(g);
    chk("grant_mid", g, 0);
    @(posedge clk);
    #1;
    set_req(0, RD, 0, 0, 1'b0);
    @(negedge clk);
    chk("name_live", be_filename, 32'h6463_6261);
    #1 rst_n = 1'b0;
    #1 chk_idle_outputs("async_rst");
    repeat (3) begin
      @(negedge clk);
      chk("rst_norsp", rsp_valid, 0);
    end
    rst_n = 1'b1;
    model_reset();
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", {rsp_valid, be_rden, be_wren, be_del}, 0);
    end
    txn(0, RD, 5, 0);
    txn(1, WR, 6, 32'h7777_7777);

    for (int n = 0; n < 150; n++) begin
      ch = int'($urandom_range(0, NCH - 1));
      r  = int'($urandom_range(0, 9));
      op = (r < 4) ? OPN : (r < 6 || r == 9) ? RD : (r < 8) ? WR : DEL;
      a  = $urandom_range(0, 255);
      d  = $urandom;
      if (op == OPN) begin
        if (d[7:0] == 8'h0) d[7:0] = 8'h5A;
        if ($urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(1, 3));
          d[8*r +: 8] = 8'h00;
        end
      end
      txn(ch, op, a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
